mem_wb_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM register.
- Consumes the EX/MEM outputs and performs data-memory access:
  - byte/half/word loads and stores, little-endian;
  - sign/zero extension on loads;
  - alignment checking.
- Registers the result into the MEM/WB pipeline register, with stall and flush control, and selects the write-back value for the register file.

---
 rtl/mem_wb_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage of the 5-stage MIPS pipeline plus the MEM/WB register.
//
// Performs little-endian byte/half/word loads and stores against a local data
// memory, with sign/zero extension of loads and alignment checking. The result
// is registered into the MEM/WB pipeline register, which supports stall and
// flush, and the write-back value for the register file is selected.
//
// Optional feature macro: MEM_STATS_EN adds load/store/fault statistics counters.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall, flush               hold MEM/WB / insert bubble (both suppress stores)
//   ex_*                       EX/MEM pipeline register contents
//   wb_valid, wb_reg_write     MEM/WB valid and register-file write enable
//   wb_dest, wb_data           register-file write address and data
//   wb_fault                   registered misalignment fault
//   stat_loads/stores/faults   statistics counters (MEM_STATS_EN only)
//   mem_fwd_data               combinational MEM-stage result for forwarding
module mem_wb_stage #(
   parameter int DMEM_ADDR_W = 10,
   parameter int WB_SEL_W    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                flush,
   input  logic                ex_valid,
   input  logic [31:0]         ex_alu_result,
   input  logic [31:0]         ex_store_data,
   input  logic [31:0]         ex_pc_plus8,
   input  logic [4:0]          ex_dest,
   input  logic                ex_reg_write,
   input  logic                ex_mem_read,
   input  logic                ex_mem_write,
   input  logic [1:0]          ex_mem_size,
   input  logic                ex_load_unsigned,
   input  logic [WB_SEL_W-1:0] ex_wb_sel,
   output logic                wb_valid,
   output logic                wb_reg_write,
   output logic [4:0]          wb_dest,
   output logic [31:0]         wb_data,
   output logic                wb_fault,
`ifdef MEM_STATS_EN
   output logic [31:0]         stat_loads,
   output logic [31:0]         stat_stores,
   output logic [15:0]         stat_faults,
`endif
   output logic [31:0]         mem_fwd_data
);

   localparam int DEPTH = 1 << DMEM_ADDR_W;

   logic [31:0]            mem [DEPTH];
   logic [DMEM_ADDR_W-1:0] idx;
   logic [1:0]             lane;
   logic                   access;
   logic                   fault;
   logic                   store_en;
   logic                   ext;
   logic [31:0]            rd_word;
   logic [7:0]             ld_byte;
   logic [15:0]            ld_half;
   logic [31:0]            load_data;
   logic [31:0]            wr_mask;
   logic [31:0]            wr_data;
   logic [31:0]            sel_data;

   logic                   wb_valid_q, wb_valid_d;
   logic                   wb_reg_write_q, wb_reg_write_d;
   logic [4:0]             wb_dest_q, wb_dest_d;
   logic [31:0]            wb_data_q, wb_data_d;
   logic                   wb_fault_q, wb_fault_d;

   always_comb begin
      // upper address bits are ignored, so accesses wrap modulo memory size
      idx      = ex_alu_result[DMEM_ADDR_W+1:2];
      lane     = ex_alu_result[1:0];
      access   = ex_valid & (ex_mem_read | ex_mem_write);
      fault    = access & ((ex_mem_size == 2'b11) |
                           ((ex_mem_size == 2'b01) & lane[0]) |
                           ((ex_mem_size == 2'b10) & (lane != 2'b00)));
      store_en = ex_valid & ex_mem_write & ~fault & ~stall & ~flush;
      // read port always sees the pre-store word, so a simultaneous read+write
      // returns old data while the store still commits
      rd_word  = mem[idx];
      ld_byte  = rd_word[{lane, 3'b000} +: 8];
      ld_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
      ext      = ~ex_load_unsigned;
      load_data = fault                 ? 32'h0 :
                  ex_mem_size == 2'b00  ? {{24{ext & ld_byte[7]}}, ld_byte} :
                  ex_mem_size == 2'b01  ? {{16{ext & ld_half[15]}}, ld_half} :
                  ex_mem_size == 2'b10  ? rd_word : 32'h0;
      wr_mask  = ex_mem_size == 2'b00 ? 32'h0000_00FF << {lane, 3'b000} :
                 ex_mem_size == 2'b01 ? (lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) :
                 32'hFFFF_FFFF;
      wr_data  = ex_mem_size == 2'b00 ? {4{ex_store_data[7:0]}} :
                 ex_mem_size == 2'b01 ? {2{ex_store_data[15:0]}} : ex_store_data;
      sel_data = ex_wb_sel == WB_SEL_W'(1) ? load_data :
                 ex_wb_sel == WB_SEL_W'(2) ? ex_pc_plus8 : ex_alu_result;
      mem_fwd_data = sel_data;
   end

   // memory has no reset value; holding rst_n low only blocks the write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
      end else if (store_en) begin
         mem[idx] <= (rd_word & ~wr_mask) | (wr_data & wr_mask);
      end
   end

   always_comb begin
      wb_valid_d     = wb_valid_q;
      wb_reg_write_d = wb_reg_write_q;
      wb_dest_d      = wb_dest_q;
      wb_data_d      = wb_data_q;
      wb_fault_d     = wb_fault_q;
      if (flush) begin
         wb_valid_d     = 1'b0;
         wb_reg_write_d = 1'b0;
         wb_dest_d      = 5'd0;
         wb_data_d      = 32'h0;
         wb_fault_d     = 1'b0;
      end else if (!stall) begin
         wb_valid_d     = ex_valid;
         wb_reg_write_d = ex_valid & ex_reg_write & ~fault & (ex_dest != 5'd0);
         wb_dest_d      = ex_dest;
         wb_data_d      = sel_data;
         wb_fault_d     = fault;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q     <= 1'b0;
         wb_reg_write_q <= 1'b0;
         wb_dest_q      <= 5'd0;
         wb_data_q      <= 32'h0;
         wb_fault_q     <= 1'b0;
      end else begin
         wb_valid_q     <= wb_valid_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_dest_q      <= wb_dest_d;
         wb_data_q      <= wb_data_d;
         wb_fault_q     <= wb_fault_d;
      end
   end

   assign wb_valid     = wb_valid_q;
   assign wb_reg_write = wb_reg_write_q;
   assign wb_dest      = wb_dest_q;
   assign wb_data      = wb_data_q;
   assign wb_fault     = wb_fault_q;

`ifdef MEM_STATS_EN
   logic        adv;
   logic [31:0] loads_q, loads_d;
   logic [31:0] stores_q, stores_d;
   logic [15:0] faults_q, faults_d;

   always_comb begin
      adv      = ex_valid & ~stall & ~flush;
      // a read+write instruction is a store, not a load
      loads_d  = loads_q + 32'(adv & ex_mem_read & ~ex_mem_write);
      stores_d = stores_q + 32'(store_en);
      faults_d = faults_q + 16'(adv & fault & (faults_q != 16'hFFFF));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loads_q  <= 32'h0;
         stores_q <= 32'h0;
         faults_q <= 16'h0;
      end else begin
         loads_q  <= loads_d;
         stores_q <= stores_d;
         faults_q <= faults_d;
      end
   end

   assign stat_loads  = loads_q;
   assign stat_stores = stores_q;
   assign stat_faults = faults_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and random checks of mem_wb_stage against a byte-level memory model.
module tb_mem_wb_stage;

   localparam int AW = 10;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_load_unsigned;
   logic [31:0] ex_alu_result, ex_store_data, ex_pc_plus8;
   logic [4:0]  ex_dest;
   logic [1:0]  ex_mem_size, ex_wb_sel;
   logic        wb_valid, wb_reg_write, wb_fault;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data, mem_fwd_data;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0]  refm [1 << (AW + 2)];
   logic        e_valid, e_rw, e_fault;
   logic [4:0]  e_dest;
   logic [31:0] e_data;

   mem_wb_stage #(.DMEM_ADDR_W(AW), .WB_SEL_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_pc_plus8(ex_pc_plus8),
      .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size), .ex_load_unsigned(ex_load_unsigned),
      .ex_wb_sel(ex_wb_sel), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
      .wb_data(wb_data), .wb_fault(wb_fault), .mem_fwd_data(mem_fwd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int baddr(input logic [31:0] a);
      return int'(a) & ((1 << (AW + 2)) - 1);
   endfunction

   // value a load of 2^sz bytes would return from the naturally aligned container
   function automatic logic [31:0] ld_val(input logic [31:0] a, input logic [1:0] sz, input logic uns);
      int n = 1 << sz;
      int base = baddr(a) & ~(n - 1);
      logic [63:0] v = 64'h0;
      if (sz == 2'd3) return 32'h0;
      for (int i = 0; i < n; i++) v = v | (64'(refm[base + i]) << (8 * i));
      if (!uns && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      return v[31:0];
   endfunction

   function automatic logic misaligned(input logic [31:0] a, input logic [1:0] sz);
      return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
   endfunction

   task automatic zero_model();
      e_valid = 0; e_rw = 0; e_fault = 0; e_dest = 0; e_data = 0;
   endtask

   task automatic tick();
      logic        flt, cmt;
      logic [31:0] sel_v;
      int          base;
      flt = ex_valid && (ex_mem_read || ex_mem_write) && misaligned(ex_alu_result, ex_mem_size);
      sel_v = ex_wb_sel == 2'd1 ? (flt ? 32'h0 : ld_val(ex_alu_result, ex_mem_size, ex_load_unsigned)) :
              ex_wb_sel == 2'd2 ? ex_pc_plus8 : ex_alu_result;
      cmt = ex_valid && ex_mem_write && !flt && !stall && !flush;
      #1 chk("fwd", mem_fwd_data, sel_v);
      @(posedge clk);
      if (!rst_n) zero_model();
      else begin
         if (cmt) begin
            base = baddr(ex_alu_result);
            for (int i = 0; i < (1 << ex_mem_size); i++) refm[base + i] = ex_store_data[8 * i +: 8];
         end
         if (flush) zero_model();
         else if (!stall) begin
            e_valid = ex_valid;
            e_rw    = ex_valid && ex_reg_write && !flt && ex_dest != 0;
            e_dest  = ex_dest;
            e_data  = sel_v;
            e_fault = flt;
         end
      end
      #1;
      chk("wb_valid", 32'(wb_valid), 32'(e_valid));
      chk("wb_reg_write", 32'(wb_reg_write), 32'(e_rw));
      chk("wb_dest", 32'(wb_dest), 32'(e_dest));
      chk("wb_data", wb_data, e_data);
      chk("wb_fault", 32'(wb_fault), 32'(e_fault));
      @(negedge clk);
   endtask

   task automatic idle();
      ex_valid = 0; ex_alu_result = 0; ex_store_data = 0; ex_pc_plus8 = 0; ex_dest = 0;
      ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_size = 0;
      ex_load_unsigned = 0; ex_wb_sel = 0;
   endtask

   task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic uns, input logic [4:0] d);
      idle();
      ex_valid = 1; ex_alu_result = a; ex_mem_size = sz; ex_load_unsigned = uns;
      ex_dest = d; ex_reg_write = 1; ex_mem_read = 1; ex_wb_sel = 2'd1;
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] dat, input logic [1:0] sz);
      idle();
      ex_valid = 1; ex_alu_result = a; ex_store_data = dat; ex_mem_size = sz; ex_mem_write = 1;
   endtask

   initial begin
      logic [31:0] r;
      rst_n = 0; stall = 0; flush = 0;
      idle();
      zero_model();
      @(negedge clk);
      tick();
      tick();
      rst_n = 1;
      for (int w = 0; w < 64; w++) begin
         st(32'(w * 4), $urandom, 2'd2);
         tick();
      end
      st(32'h10, 32'hDEADBEEF, 2'd2); tick();
      ld(32'h10, 2'd2, 0, 5'd8); tick();
      chk("lw_data", wb_data, 32'hDEADBEEF);
      chk("lw_rw", 32'(wb_reg_write), 32'd1);
      chk("lw_dest", 32'(wb_dest), 32'd8);
      st(32'h13, 32'h7F, 2'd0); tick();
      ld(32'h13, 2'd0, 0, 5'd9); tick();
      chk("lb_pos", wb_data, 32'h0000007F);
      st(32'h12, 32'h80, 2'd0); tick();
      ld(32'h12, 2'd0, 0, 5'd9); tick();
      chk("lb_neg", wb_data, 32'hFFFFFF80);
      ld(32'h12, 2'd0, 1, 5'd9); tick();
      chk("lbu", wb_data, 32'h00000080);
      ld(32'h10, 2'd2, 0, 5'd9); tick();
      chk("lw_merged", wb_data, 32'h7F80BEEF);
      ld(32'h21, 2'd1, 0, 5'd10); tick();
      chk("lh_fault", 32'(wb_fault), 32'd1);
      chk("lh_fault_rw", 32'(wb_reg_write), 32'd0);
      chk("lh_fault_data", wb_data, 32'h0);
      st(32'h22, 32'hCAFEF00D, 2'd2); tick();
      chk("sw_fault", 32'(wb_fault), 32'd1);
      ld(32'h20, 2'd2, 0, 5'd11); tick();
      ld(32'h10, 2'd2, 0, 5'd5); tick();
      st(32'h40, 32'h1234, 2'd2);
      ex_wb_sel = 2'd1;
      stall = 1;
      repeat (3) tick();
      chk("stall_hold_dest", 32'(wb_dest), 32'd5);
      chk("stall_hold_data", wb_data, 32'h7F80BEEF);
      stall = 0; tick();
      ld(32'h40, 2'd2, 0, 5'd6); tick();
      chk("stall_store", wb_data, 32'h00001234);
      st(32'h40, 32'h5678, 2'd2);
      stall = 1; flush = 1; tick();
      chk("flush_bubble", 32'(wb_valid), 32'd0);
      stall = 0; flush = 0;
      ld(32'h40, 2'd2, 0, 5'd6); tick();
      chk("flush_no_store", wb_data, 32'h00001234);
      idle();
      ex_valid = 1; ex_reg_write = 1; ex_wb_sel = 2'd2; ex_pc_plus8 = 32'h00400008;
      ex_dest = 5'd31; ex_alu_result = 32'h00000123;
      tick();
      chk("jal_data", wb_data, 32'h00400008);
      chk("jal_rw", 32'(wb_reg_write), 32'd1);
      ex_dest = 5'd0; tick();
      chk("jal_r0_rw", 32'(wb_reg_write), 32'd0);
      st(32'h44, 32'hAAAA5555, 2'd2);
      rst_n = 0; tick();
      rst_n = 1;
      ld(32'h44, 2'd2, 0, 5'd7); tick();
      ld(32'h10, 2'd2, 0, 5'd7); tick();
      chk("pre_async_valid", 32'(wb_valid), 32'd1);
      #2 rst_n = 0;
      #1;
      zero_model();
      chk("async_valid", 32'(wb_valid), 32'd0);
      chk("async_data", wb_data, 32'h0);
      @(negedge clk);
      rst_n = 1;
      idle();
      tick();
      for (int k = 0; k < 400; k++) begin
         int op;
         idle();
         ex_valid = ($urandom % 8) != 0;
         op = $urandom % 4;
         ex_mem_read = op[0];
         ex_mem_write = op[1];
         ex_mem_size = 2'($urandom);
         if (ex_mem_size == 2'd3 && !(ex_valid && (ex_mem_read || ex_mem_write))) ex_mem_size = 2'd2;
         r = $urandom;
         ex_alu_result = {r[31:12], 4'h0, r[7:0]};
         ex_store_data = $urandom;
         ex_pc_plus8 = $urandom;
         ex_dest = 5'($urandom);
         ex_reg_write = 1'($urandom);
         ex_load_unsigned = 1'($urandom);
         ex_wb_sel = 2'($urandom);
         stall = ($urandom % 8) == 0;
         flush = ($urandom % 10) == 0;
         tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
